// File: rtl/bist_sig_checker.sv
// BIST session sequencer: seeds and runs the SISA for a programmed cycle count, then captures and checks the signature.
// Latency N+2 cycles from start acceptance to done; start is ignored while a session is in flight.
module bist_sig_checker #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] sig,
    output logic             sisa_rst,
    output logic             sisa_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] gold_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sisa_rst  = (state == S_INIT);
        sisa_en   = (state == S_RUN);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                // A zero-length session skips RUN so the seed itself is captured.
                state_nxt = (n_reg == '0) ? S_CAPTURE : S_RUN;
            end
            S_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_reg     <= '0;
            gold_reg  <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= '0;
        end else begin
            if (accept) begin
                n_reg    <= num_cycles;
                gold_reg <= golden;
                busy     <= 1'b1;
                done     <= 1'b0;
                pass     <= 1'b0;
            end
            case (state)
                S_INIT: cnt <= n_reg;
                S_RUN:  cnt <= cnt - CNT_W'(1);
                S_CAPTURE: begin
                    signature <= sig;
                    pass      <= (sig == gold_reg);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_sig_checker.sv
// Directed and randomized BIST sessions checked against a timeline model of the session rules.
module tb_bist_sig_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_cycles;
    logic [9:0] golden;
    logic [9:0] sig;
    logic       sisa_rst;
    logic       sisa_en;
    logic       busy;
    logic       done;
    logic       pass;
    logic [9:0] signature;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bist_sig_checker #(.WIDTH(10), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_cycles (num_cycles),
        .golden     (golden),
        .sig        (sig),
        .sisa_rst   (sisa_rst),
        .sisa_en    (sisa_en),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic b, input logic d,
                                 input logic p, input logic [9:0] s);
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".pass"}, 32'(pass), 32'(p));
        check({tag, ".signature"}, 32'(signature), 32'(s));
        check({tag, ".sisa"}, {30'd0, sisa_rst, sisa_en}, 32'd0);
    endtask

    // One session: n enable cycles expected, done on the (n+2)th edge after acceptance.
    // mid>0 pulses a conflicting start during the session; late pulses start into the CAPTURE edge.
    task automatic session(input string tag, input int n, input logic [9:0] s,
                           input logic [9:0] g, input int mid, input bit late);
        int en_cnt, en_first, en_last, rst_cnt, done_k, busy_gap;
        en_cnt = 0; en_first = -1; en_last = -1; rst_cnt = 0; done_k = -1; busy_gap = 0;
        sig = s; num_cycles = 8'(n); golden = g; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        num_cycles = 8'($urandom);
        golden = 10'($urandom);
        check({tag, ".accept_busy"}, 32'(busy), 32'd1);
        check({tag, ".accept_clear"}, {30'd0, done, pass}, 32'd0);
        if (sisa_rst) rst_cnt++;
        if (sisa_en) en_cnt++;
        for (int k = 1; k <= n + 12; k++) begin
            @(negedge clk);
            if (sisa_rst) rst_cnt++;
            if (sisa_en) begin
                en_cnt++;
                if (en_first < 0) en_first = k;
                en_last = k;
            end
            if (!busy && !done) busy_gap++;
            if (done) begin
                done_k = k;
                break;
            end
            start = 1'b0;
            if (mid > 0 && k == mid) begin
                start = 1'b1;
                num_cycles = 8'(n + 5);
                golden = ~g;
            end
            if (late && k == n + 1) start = 1'b1;
        end
        start = 1'b0;
        check({tag, ".done_cycle"}, 32'(done_k), 32'(n + 2));
        check({tag, ".en_count"}, 32'(en_cnt), 32'(n));
        if (n > 0) begin
            check({tag, ".en_window"}, {16'(en_first), 16'(en_last)}, {16'd1, 16'(n)});
        end
        check({tag, ".sisa_rst_count"}, 32'(rst_cnt), 32'd1);
        check({tag, ".busy_gap"}, 32'(busy_gap), 32'd0);
        check_outputs({tag, ".result"}, 1'b0, 1'b1, s == g, s);
    endtask

    initial begin
        logic [9:0] rs, rg;
        int rn, nz;
        rst = 1'b1; start = 1'b0; num_cycles = '0; golden = '0; sig = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 10'h000);
        nz = 0;
        repeat (10) begin
            @(negedge clk);
            if ({sisa_rst, sisa_en, busy, done, pass, signature} != '0) nz++;
        end
        check("idle_quiet", 32'(nz), 32'd0);

        session("match24", 24, 10'h2A5, 10'h2A5, 0, 1'b0);
        session("miss24", 24, 10'h2A5, 10'h2A4, 0, 1'b0);
        session("rematch24", 24, 10'h2A5, 10'h2A5, 0, 1'b1);
        // The late start must not have launched a new session; DONE holds.
        repeat (5) @(negedge clk);
        check_outputs("done_hold", 1'b0, 1'b1, 1'b1, 10'h2A5);

        session("zero", 0, 10'h155, 10'h155, 0, 1'b0);
        session("max255", 255, 10'h0F3, 10'h0F3, 0, 1'b0);
        session("ignore_mid", 24, 10'h2A5, 10'h2A5, 6, 1'b0);

        // Reset during RUN cycle 10 of a 24-cycle session.
        sig = 10'h3C1; num_cycles = 8'd24; golden = 10'h000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_run_en", 32'(sisa_en), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_outputs("mid_run_reset", 1'b0, 1'b0, 1'b0, 10'h000);
        session("after_reset", 24, 10'h2A5, 10'h2A5, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rn = $urandom_range(0, 40);
            rs = 10'($urandom);
            rg = ($urandom_range(0, 1) == 1) ? rs : 10'($urandom);
            session($sformatf("rand%0d", i), rn, rs, rg, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
